fp_mul_arbiter: RTL and testbench
=================================

# fp_mul_arbiter

Controller that shares one sequential `fp_multiplier` between two requesters. It arbitrates round-robin, latches operands, and derives the multiplier's `leading_one` configuration. It sequences the multiplier through load (`reset` high) and compute (`reset` low) windows for fixed cycle counts, captures `out`/`of`/`uf`, and returns the result to the winning requester over a valid/ready response channel. It sits between the FP unit's issue ports and the single multiplier instance.

## Interface
- `WIDTH`, 32: operand/result width (IEEE-754 single).
- `LOAD_CYCLES`, 2: cycles `mul_reset` is held high with operands stable (≥1).
- `MUL_CYCLES`, 26: cycles after `mul_reset` falls until multiplier outputs are valid (≥1).

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req0_valid` in 1 / `req0_ready` out 1 / `req0_a` in WIDTH / `req0_b` in WIDTH: requester 0 operand channel.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same for requester 1.
- `rsp0_valid` out 1 / `rsp0_ready` in 1 / `rsp0_data` out WIDTH / `rsp0_of` out 1 / `rsp0_uf` out 1: requester 0 result channel.
- `rsp1_valid`, `rsp1_ready`, `rsp1_data`, `rsp1_of`, `rsp1_uf`: same for requester 1.
- `mul_a` out WIDTH, `mul_b` out WIDTH: operands to multiplier (registered).
- `mul_leading_one` out 2: `2'b00` if either operand exponent field [30:23] is 0, else `2'b01`.
- `mul_reset` out 1: multiplier reset/start control (registered).
- `mul_out` in WIDTH, `mul_of` in 1, `mul_uf` in 1: multiplier results.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, LOAD, COMPUTE, RESP. One operation in flight total.
- IDLE: `mul_reset`=1. Grant:
  - one valid → that requester;
  - both valid → requester ≠ `last_grant`.
  - `reqN_ready`=1 combinationally only for the granted requester; both 0 outside IDLE and during reset.
  - On handshake: latch a/b into `mul_a`/`mul_b`, compute `mul_leading_one`, record `grant_id`, set `last_grant`=`grant_id`, load counter = `LOAD_CYCLES`-1, go to LOAD.
- LOAD: `mul_reset`=1. Decrement the counter each cycle. At 0, load `MUL_CYCLES`-1 and go to COMPUTE.
- COMPUTE: `mul_reset`=0. Decrement the counter. At 0, capture `mul_out`/`mul_of`/`mul_uf` into the result registers and go to RESP.
- RESP: `rsp<grant_id>_valid`=1; the other response valid stays 0. Data/of/uf are held stable until `ready`. On handshake, go to IDLE; `mul_reset` returns to 1 on that edge.
- `mul_a`, `mul_b`, `mul_leading_one` hold their values from acceptance until the next acceptance.
- Reset (any state, including mid-LOAD/COMPUTE/RESP): next state IDLE and `last_grant`=1 (requester 0 wins the first tie). The pending op is dropped with no response.
- Reset values of all outputs: `mul_reset`=1; all others 0 (`mul_a`, `mul_b`, `mul_leading_one`, `rsp*_valid`, `rsp*_data`, `rsp*_of`, `rsp*_uf`, `req*_ready`, `busy`).
- The controller does not inspect or alter result bits; of/uf are passed through as captured.

## Timing
- Request handshake at edge E0. LOAD occupies the `LOAD_CYCLES` cycles after E0. COMPUTE occupies the next `MUL_CYCLES` cycles.
- `rsp_valid` rises after edge E0+`LOAD_CYCLES`+`MUL_CYCLES` (defaults: 28 cycles).
- A response handshake in the same cycle `rsp_valid` rises completes that edge. The earliest next acceptance is the following cycle (one IDLE cycle minimum between ops).
- A requester holding valid while the other is granted waits at least one full operation. Fairness: with both continuously valid, grants strictly alternate.

## Test plan
- Single op: req0 a=0x40000000 (2.0), b=0x40E00000 (7.0) → `mul_leading_one`=01, `mul_reset` high for 2 cycles then low. `rsp0_valid` 28 cycles after handshake, data 0x41600000, of=uf=0. `rsp1_valid` stays 0.
- Contention: after reset, both valid in the same cycle.
  - req0 3.0×3.0 (0x40400000 each) and req1 −2.0×−5.0 (0xC0000000, 0xC0A00000): req0 granted first → 0x41100000, then req1 → 0x41200000.
  - Repeat both valid: req1 granted first.
- Zero operand: a=0x43570000, b=0x00000000 → `mul_leading_one`=00, rsp data 0x00000000.
- Backpressure: hold `rsp0_ready`=0 for 10 cycles after `rsp0_valid` → valid/data stable, `req1_ready`=0 throughout with req1 valid. Raise ready → IDLE, req1 accepted next cycle.
- Overflow passthrough: a=0x7F2A8000, b=0xBFD53800 → `rsp_of`=1 as driven by the multiplier.
- Reset mid-COMPUTE (10 cycles in): next cycle `mul_reset`=1, `busy`=0, no `rsp*_valid` ever for that op. A new req0 is accepted and completes normally.

Source files
------------

// File: rtl/fp_mul_arbiter_if.sv
// Bus bundle between the FP unit issue/result ports, the arbiter and the
// shared sequential multiplier. The arbiter takes the slave view; the
// requesters and the multiplier together form the master view.
interface fp_mul_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_data;
  logic             rsp0_of;
  logic             rsp0_uf;

  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_data;
  logic             rsp1_of;
  logic             rsp1_uf;

  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [1:0]       mul_leading_one;
  logic             mul_reset;
  logic [WIDTH-1:0] mul_out;
  logic             mul_of;
  logic             mul_uf;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output rsp0_valid, rsp0_data, rsp0_of, rsp0_uf,
    input  rsp0_ready,
    output rsp1_valid, rsp1_data, rsp1_of, rsp1_uf,
    input  rsp1_ready,
    output mul_a, mul_b, mul_leading_one, mul_reset,
    input  mul_out, mul_of, mul_uf
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  rsp0_valid, rsp0_data, rsp0_of, rsp0_uf,
    output rsp0_ready,
    input  rsp1_valid, rsp1_data, rsp1_of, rsp1_uf,
    output rsp1_ready,
    input  mul_a, mul_b, mul_leading_one, mul_reset,
    output mul_out, mul_of, mul_uf
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin front end that time-shares one sequential fp_multiplier
// between two requesters and returns each result on its own channel.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | mul_reset high, waiting for a request; grant is combinational
// S_LOAD    | operands stable, mul_reset held high for LOAD_CYCLES cycles
// S_COMPUTE | mul_reset low for MUL_CYCLES cycles, result captured at end
// S_RESP    | result presented to the granted requester until accepted
module fp_mul_arbiter #(
  parameter int WIDTH       = 32,
  parameter int LOAD_CYCLES = 2,
  parameter int MUL_CYCLES  = 26
) (
  input  logic               clk,
  input  logic               reset,
  fp_mul_arbiter_if.slave    bus,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_RESP
  } state_t;

  localparam int CNT_MAX = (LOAD_CYCLES > MUL_CYCLES) ? LOAD_CYCLES : MUL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'(MUL_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             grant_id;
  logic             last_grant;
  logic [WIDTH-1:0] mul_a_q;
  logic [WIDTH-1:0] mul_b_q;
  logic [1:0]       lead_q;
  logic             mul_reset_q;
  logic [WIDTH-1:0] res_data;
  logic             res_of;
  logic             res_uf;
  logic             rsp0_valid_q;
  logic             rsp1_valid_q;

  logic             grant_ok;
  logic             grant_sel;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             rsp_fire;

  // Round-robin grant: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    grant_ok  = 1'b0;
    grant_sel = 1'b0;
    if (state == S_IDLE && !reset) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_ok  = 1'b1;
        grant_sel = ~last_grant;
      end else if (bus.req0_valid) begin
        grant_ok  = 1'b1;
        grant_sel = 1'b0;
      end else if (bus.req1_valid) begin
        grant_ok  = 1'b1;
        grant_sel = 1'b1;
      end
    end
  end

  assign bus.req0_ready = grant_ok & ~grant_sel;
  assign bus.req1_ready = grant_ok &  grant_sel;

  assign sel_a    = grant_sel ? bus.req1_a : bus.req0_a;
  assign sel_b    = grant_sel ? bus.req1_b : bus.req0_b;
  assign rsp_fire = (rsp0_valid_q & bus.rsp0_ready) | (rsp1_valid_q & bus.rsp1_ready);

  // Sequencer: accept, hold multiplier in load, let it run, then hand back the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      grant_id     <= 1'b0;
      last_grant   <= 1'b1;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      lead_q       <= 2'b00;
      mul_reset_q  <= 1'b1;
      res_data     <= '0;
      res_of       <= 1'b0;
      res_uf       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          mul_reset_q <= 1'b1;
          if (grant_ok) begin
            mul_a_q    <= sel_a;
            mul_b_q    <= sel_b;
            // Denormal/zero operands have no implicit leading one.
            lead_q     <= ((sel_a[30:23] == 8'd0) || (sel_b[30:23] == 8'd0)) ? 2'b00 : 2'b01;
            grant_id   <= grant_sel;
            last_grant <= grant_sel;
            cnt        <= LOAD_LAST;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (cnt == '0) begin
            cnt         <= MUL_LAST;
            mul_reset_q <= 1'b0;
            state       <= S_COMPUTE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_COMPUTE: begin
          if (cnt == '0) begin
            res_data     <= bus.mul_out;
            res_of       <= bus.mul_of;
            res_uf       <= bus.mul_uf;
            rsp0_valid_q <= ~grant_id;
            rsp1_valid_q <=  grant_id;
            state        <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_fire) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            mul_reset_q  <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: begin
          state       <= S_IDLE;
          mul_reset_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.mul_a           = mul_a_q;
  assign bus.mul_b           = mul_b_q;
  assign bus.mul_leading_one = lead_q;
  assign bus.mul_reset       = mul_reset_q;

  // Both channels see the same result register; only the granted valid rises.
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp0_data  = res_data;
  assign bus.rsp0_of    = res_of;
  assign bus.rsp0_uf    = res_uf;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp1_data  = res_data;
  assign bus.rsp1_of    = res_of;
  assign bus.rsp1_uf    = res_uf;

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a small timed model of the multiplier.
module tb_fp_mul_arbiter;
  localparam int WIDTH = 32;
  localparam int MUL_CYCLES = 26;
  localparam int EXP_LAT = 28;

  logic clk;
  logic reset;
  logic busy;
  int   n_tests;
  int   n_fail;
  int   low_cnt;

  fp_mul_arbiter_if #(.WIDTH(WIDTH)) bus ();

  fp_mul_arbiter #(.WIDTH(WIDTH), .LOAD_CYCLES(2), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: result appears only once mul_reset has been low long enough.
  always @(posedge clk) begin
    if (bus.mul_reset) low_cnt <= 0;
    else               low_cnt <= low_cnt + 1;
  end

  logic [31:0] ref_out;
  logic        ref_of;
  logic        ref_uf;
  always_comb begin
    ref_out = 32'hDEADBEEF;
    ref_of  = 1'b0;
    ref_uf  = 1'b0;
    case ({bus.mul_a, bus.mul_b})
      {32'h40000000, 32'h40E00000}: ref_out = 32'h41600000;
      {32'h40400000, 32'h40400000}: ref_out = 32'h41100000;
      {32'hC0000000, 32'hC0A00000}: ref_out = 32'h41200000;
      {32'h43570000, 32'h00000000}: ref_out = 32'h00000000;
      {32'h7F2A8000, 32'hBFD53800}: begin ref_out = 32'hFF800000; ref_of = 1'b1; end
      {32'h00800000, 32'h00800000}: begin ref_out = 32'h00000000; ref_uf = 1'b1; end
      default: ;
    endcase
  end

  wire out_ok = !bus.mul_reset && (low_cnt >= MUL_CYCLES - 1);
  assign bus.mul_out = out_ok ? ref_out : 32'hDEADBEEF;
  assign bus.mul_of  = out_ok ? ref_of  : 1'b1;
  assign bus.mul_uf  = out_ok ? ref_uf  : 1'b1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with reqN_valid already driven; returns after the handshake edge.
  task automatic accept(input int which, input int exp_wait, input string tag);
    int w;
    logic rdy;
    w = 0;
    #1;
    rdy = which ? bus.req1_ready : bus.req0_ready;
    while (!rdy && w < 40) begin
      @(negedge clk); #1;
      w++;
      rdy = which ? bus.req1_ready : bus.req0_ready;
    end
    check_val({tag, "_grant_wait"}, 64'(w), 64'(exp_wait));
    check_val({tag, "_other_ready"}, which ? bus.req0_ready : bus.req1_ready, 1'b0);
    @(posedge clk); #1;
    if (which) bus.req1_valid = 1'b0;
    else       bus.req0_valid = 1'b0;
  endtask

  // Follows one accepted op to its response; ends at the negedge after the response handshake.
  task automatic finish_op(input int which, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] lo, input logic [31:0] data,
                           input logic of, input logic uf, input int hold, input string tag);
    int lat, mr_hi, other_v, other_r;
    logic got;
    logic [31:0] d;
    lat = 0; mr_hi = 0; other_v = 0; other_r = 0; got = 1'b0;
    if (which) bus.rsp1_ready = (hold == 0);
    else       bus.rsp0_ready = (hold == 0);
    @(negedge clk);
    check_val({tag, "_mul_a"}, bus.mul_a, a);
    check_val({tag, "_mul_b"}, bus.mul_b, b);
    check_val({tag, "_lead"}, bus.mul_leading_one, lo);
    check_val({tag, "_busy"}, busy, 1'b1);
    while (!got && lat < 80) begin
      got = which ? bus.rsp1_valid : bus.rsp0_valid;
      if (!got) begin
        if (which ? bus.rsp0_valid : bus.rsp1_valid) other_v++;
        if (which ? bus.req0_ready : bus.req1_ready) other_r++;
        if (bus.mul_reset) mr_hi++;
        @(posedge clk); lat++;
        @(negedge clk);
      end
    end
    check_val({tag, "_rsp_seen"}, got, 1'b1);
    check_val({tag, "_latency"}, 64'(lat), 64'(EXP_LAT));
    check_val({tag, "_load_cycles"}, 64'(mr_hi), 64'd2);
    check_val({tag, "_other_valid"}, 64'(other_v), 64'd0);
    check_val({tag, "_other_ready"}, 64'(other_r), 64'd0);
    check_val({tag, "_mulrst_resp"}, bus.mul_reset, 1'b0);
    d = which ? bus.rsp1_data : bus.rsp0_data;
    check_val({tag, "_data"}, d, data);
    check_val({tag, "_of"}, which ? bus.rsp1_of : bus.rsp0_of, of);
    check_val({tag, "_uf"}, which ? bus.rsp1_uf : bus.rsp0_uf, uf);
    check_val({tag, "_ops_held"}, {bus.mul_a, bus.mul_b}, {a, b});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_val({tag, "_hold_valid"}, which ? bus.rsp1_valid : bus.rsp0_valid, 1'b1);
      check_val({tag, "_hold_data"}, which ? bus.rsp1_data : bus.rsp0_data, data);
      check_val({tag, "_hold_oready"}, which ? bus.req0_ready : bus.req1_ready, 1'b0);
    end
    if (which) bus.rsp1_ready = 1'b1;
    else       bus.rsp0_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val({tag, "_valid_drop"}, which ? bus.rsp1_valid : bus.rsp0_valid, 1'b0);
    check_val({tag, "_idle_busy"}, busy, 1'b0);
    check_val({tag, "_idle_mulrst"}, bus.mul_reset, 1'b1);
  endtask

  task automatic set_req(input int which, input logic [31:0] a, input logic [31:0] b);
    if (which) begin bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1; end
    else       begin bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1; end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;

    // Reset values, with a request already pending
    set_req(0, 32'h40000000, 32'h40E00000);
    repeat (3) @(negedge clk);
    check_val("rst_mul_reset", bus.mul_reset, 1'b1);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_ready0", bus.req0_ready, 1'b0);
    check_val("rst_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
    check_val("rst_mul_ab", {bus.mul_a, bus.mul_b}, 64'd0);
    check_val("rst_lead", bus.mul_leading_one, 2'b00);
    check_val("rst_rsp_data", {bus.rsp0_data, bus.rsp1_data}, 64'd0);
    check_val("rst_rsp_flags", {bus.rsp0_of, bus.rsp0_uf, bus.rsp1_of, bus.rsp1_uf}, 4'd0);
    reset = 1'b0;

    // Single op 2.0 * 7.0
    accept(0, 0, "single");
    finish_op(0, 32'h40000000, 32'h40E00000, 2'b01, 32'h41600000, 1'b0, 1'b0, 0, "single");

    // Contention after reset: req0 first, then req1, then req1 wins a fresh tie
    pulse_reset();
    set_req(0, 32'h40400000, 32'h40400000);
    set_req(1, 32'hC0000000, 32'hC0A00000);
    accept(0, 0, "tie1");
    finish_op(0, 32'h40400000, 32'h40400000, 2'b01, 32'h41100000, 1'b0, 1'b0, 0, "tie1");
    set_req(0, 32'h40400000, 32'h40400000);
    accept(1, 0, "tie2");
    finish_op(1, 32'hC0000000, 32'hC0A00000, 2'b01, 32'h41200000, 1'b0, 1'b0, 0, "tie2");
    accept(0, 0, "tie3");
    finish_op(0, 32'h40400000, 32'h40400000, 2'b01, 32'h41100000, 1'b0, 1'b0, 0, "tie3");

    // Zero operand clears leading one
    set_req(0, 32'h43570000, 32'h00000000);
    accept(0, 0, "zero");
    finish_op(0, 32'h43570000, 32'h00000000, 2'b00, 32'h00000000, 1'b0, 1'b0, 0, "zero");

    // Backpressure on rsp0 with req1 waiting
    set_req(0, 32'h40000000, 32'h40E00000);
    accept(0, 0, "bp0");
    set_req(1, 32'hC0000000, 32'hC0A00000);
    finish_op(0, 32'h40000000, 32'h40E00000, 2'b01, 32'h41600000, 1'b0, 1'b0, 10, "bp0");
    accept(1, 0, "bp1");
    finish_op(1, 32'hC0000000, 32'hC0A00000, 2'b01, 32'h41200000, 1'b0, 1'b0, 0, "bp1");

    // Overflow and underflow flags pass straight through
    set_req(1, 32'h7F2A8000, 32'hBFD53800);
    accept(1, 0, "ovf");
    finish_op(1, 32'h7F2A8000, 32'hBFD53800, 2'b01, 32'hFF800000, 1'b1, 1'b0, 0, "ovf");
    set_req(0, 32'h00800000, 32'h00800000);
    accept(0, 0, "unf");
    finish_op(0, 32'h00800000, 32'h00800000, 2'b01, 32'h00000000, 1'b0, 1'b1, 0, "unf");

    // Reset ten cycles into COMPUTE drops the op silently
    set_req(0, 32'h40000000, 32'h40E00000);
    accept(0, 0, "midrst");
    repeat (11) @(posedge clk);
    @(negedge clk);
    check_val("midrst_in_compute", {busy, bus.mul_reset}, 2'b10);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("midrst_mul_reset", bus.mul_reset, 1'b1);
    check_val("midrst_busy", busy, 1'b0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsp0_valid || bus.rsp1_valid) seen++;
    end
    check_val("midrst_no_rsp", 64'(seen), 64'd0);
    set_req(0, 32'h40400000, 32'h40400000);
    accept(0, 0, "postrst");
    finish_op(0, 32'h40400000, 32'h40400000, 2'b01, 32'h41100000, 1'b0, 1'b0, 0, "postrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
